// File: rtl/fcml_pwm_pkg.sv
// Shared widths, FSM encoding and ramp wrap helper for the FCML DPWM scheduler.
package fcml_pwm_pkg;
  localparam int WIDTH      = 11;
  localparam int NCELL      = 4;
  localparam int PERIOD_MIN = 8;
  localparam int CELL_SH    = $clog2(NCELL);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_e;

  // Inputs are always < 2P, so one conditional subtract is a full modulo.
  function automatic logic [WIDTH-1:0] ramp_wrap(input logic [WIDTH:0] sum,
                                                 input logic [WIDTH-1:0] p);
    logic [WIDTH:0] s;
    s = sum;
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return s[WIDTH-1:0];
  endfunction
endpackage

// File: rtl/dpwm_carrier.sv
// Period counter with boundary-only period reload and NCELL phase-shifted ramps.
module dpwm_carrier
  import fcml_pwm_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run_n,
  input  logic [WIDTH-1:0]             period_cfg,
  output logic                         wrap,
  output logic [WIDTH-1:0]             period,
  output logic [NCELL-1:0][WIDTH-1:0]  ramp_ref,
  output logic                         sync
);
  logic                        run_q;
  logic [WIDTH-1:0]            cnt_q, cnt_n, p_n, o_n, p_cfg;
  logic [NCELL-1:0][WIDTH-1:0] ramp_n;
  logic                        sync_n;

  assign wrap   = run_q && (cnt_q == period - WIDTH'(1));
  assign p_cfg  = (period_cfg < WIDTH'(PERIOD_MIN)) ? WIDTH'(PERIOD_MIN) : period_cfg;
  // Idle keeps tracking the request so the start edge latches it; running only at wrap.
  assign p_n    = (!run_q || wrap) ? p_cfg : period;
  assign o_n    = p_n >> CELL_SH;
  assign cnt_n  = (run_q && run_n && !wrap) ? cnt_q + WIDTH'(1) : '0;
  // Outputs are computed from next-state so they line up with cnt in the same cycle.
  assign sync_n = run_n && (cnt_n == p_n - WIDTH'(1));

  for (genvar k = 0; k < NCELL; k++) begin : g_cell
    logic [WIDTH:0] sum;
    assign sum       = {1'b0, cnt_n} + {1'b0, o_n} * (WIDTH+1)'(k);
    assign ramp_n[k] = run_n ? ramp_wrap(sum, p_n) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      period   <= WIDTH'(PERIOD_MIN);
      ramp_ref <= '0;
      sync     <= 1'b0;
    end else begin
      run_q    <= run_n;
      cnt_q    <= cnt_n;
      period   <= p_n;
      ramp_ref <= ramp_n;
      sync     <= sync_n;
    end
  end
endmodule

// File: rtl/dpwm_scheduler.sv
// FCML DPWM sequencer: run/stop FSM, carrier instance and double-buffered duty commands.
module dpwm_scheduler
  import fcml_pwm_pkg::*;
#(
  parameter int NPH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [WIDTH-1:0]             period_cfg,
  input  logic                         duty_valid,
  output logic                         duty_ready,
  input  logic [NPH-1:0][WIDTH-1:0]    duty_data,
  output logic [NCELL-1:0][WIDTH-1:0]  ramp_ref,
  output logic [NPH-1:0][WIDTH-1:0]    dpwm_duty,
  output logic                         sync,
  output logic                         running
);
  state_e                    st, st_n;
  logic                      run_n, wrap, accept, full, full_n;
  logic [WIDTH-1:0]          period;
  logic [NPH-1:0][WIDTH-1:0] shadow, duty_cl;

  dpwm_carrier u_carrier (
    .clk        (clk),
    .rst        (rst),
    .run_n      (run_n),
    .period_cfg (period_cfg),
    .wrap       (wrap),
    .period     (period),
    .ramp_ref   (ramp_ref),
    .sync       (sync)
  );

  always_comb begin
    st_n = st;
    case (st)
      IDLE:    if (en) st_n = RUN;
      RUN:     if (!en) st_n = STOP;
      STOP:    if (en) st_n = RUN; else if (wrap) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  assign run_n  = (st_n != IDLE);
  assign accept = duty_valid && duty_ready;
  // A wrap always empties the shadow: it is either applied or, when stopping, dropped.
  assign full_n = run_n && ((full && !wrap) || accept);

  for (genvar i = 0; i < NPH; i++) begin : g_clamp
    assign duty_cl[i] = (duty_data[i] > period) ? period : duty_data[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= IDLE;
      running    <= 1'b0;
      full       <= 1'b0;
      duty_ready <= 1'b0;
      shadow     <= '0;
      dpwm_duty  <= '0;
    end else begin
      st         <= st_n;
      running    <= run_n;
      full       <= full_n;
      duty_ready <= run_n && !full_n;
      if (accept) shadow <= duty_cl;
      if (!run_n)           dpwm_duty <= '0;
      else if (wrap && full) dpwm_duty <= shadow;
    end
  end
endmodule

// File: tb/tb_dpwm_scheduler.sv
// Directed bench for dpwm_scheduler: period table sweeps plus duty/stop/reset sequences.
module tb_dpwm_scheduler;
  localparam int W = 11;

  logic           clk = 1'b0, rst = 1'b1, en = 1'b0, duty_valid = 1'b0;
  logic           duty_ready, sync, running;
  logic [W-1:0]   period_cfg = '0;
  logic [3*W-1:0] duty_data = '0, dpwm_duty;
  logic [4*W-1:0] ramp_ref;
  int             errors = 0, checks = 0;

  typedef struct { int cfg; int p; int o; } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  dpwm_scheduler dut (
    .clk(clk), .rst(rst), .en(en), .period_cfg(period_cfg),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .duty_data(duty_data),
    .ramp_ref(ramp_ref), .dpwm_duty(dpwm_duty), .sync(sync), .running(running)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*W-1:0] ramps(input int c, input int p, input int o);
    logic [4*W-1:0] r;
    for (int k = 0; k < 4; k++) r[k*W +: W] = W'((c + k*o) % p);
    return r;
  endfunction

  function automatic logic [3*W-1:0] duty3(input int d2, input int d1, input int d0);
    return {W'(d2), W'(d1), W'(d0)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; duty_valid = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic start(input int cfg);
    do_reset();
    period_cfg = W'(cfg); en = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0] = '{100, 100, 25};
    vecs[1] = '{3, 8, 2};
    vecs[2] = '{0, 8, 2};
    vecs[3] = '{8, 8, 2};
    vecs[4] = '{13, 13, 3};
    vecs[5] = '{2047, 2047, 511};

    // reset state
    #1 rst = 1'b0;
    #2;
    chk("rst_ready", duty_ready, 0);
    chk("rst_ramp", ramp_ref, 0);
    chk("rst_duty", dpwm_duty, 0);
    chk("rst_sync", sync, 0);
    chk("rst_running", running, 0);
    tick();
    rst = 1'b1;

    // carrier sweeps: one full period plus the wrap for each requested period
    foreach (vecs[i]) begin
      start(vecs[i].cfg);
      chk("start_running", running, 1);
      chk("start_ready", duty_ready, 1);
      chk("start_ramp", ramps(0, vecs[i].p, vecs[i].o), ramp_ref);
      chk("start_sync", sync, 0);
      for (int c = 1; c < vecs[i].p; c++) begin
        tick();
        chk("sweep_ramp", ramp_ref, ramps(c, vecs[i].p, vecs[i].o));
        chk("sweep_sync", sync, (c == vecs[i].p - 1) ? 1 : 0);
      end
      tick();
      chk("wrap_ramp", ramp_ref, ramps(0, vecs[i].p, vecs[i].o));
      chk("wrap_sync", sync, 0);
    end

    // duty clamp, latency, hold-while-not-ready, accept on wrap cycle
    start(100);
    ticks(30);
    duty_valid = 1'b1; duty_data = duty3(300, 200, 50);
    tick();                                   // cnt 31
    duty_data = duty3(7, 7, 7);               // held while not ready
    chk("acc_ready_low", duty_ready, 0);
    chk("acc_duty_hold", dpwm_duty, 0);
    ticks(68);                                // cnt 99
    chk("acc_sync", sync, 1);
    chk("acc_duty_prewrap", dpwm_duty, 0);
    chk("acc_ready_prewrap", duty_ready, 0);
    duty_valid = 1'b0;
    tick();                                   // cnt 0
    chk("acc_duty_applied", dpwm_duty, duty3(100, 100, 50));
    chk("acc_ready_back", duty_ready, 1);
    ticks(100);
    chk("hold_not_consumed", dpwm_duty, duty3(100, 100, 50));
    ticks(99);                                // cnt 99: accept on wrap edge
    duty_valid = 1'b1; duty_data = duty3(10, 20, 30);
    tick();
    duty_valid = 1'b0;
    chk("wrapacc_not_bypass", dpwm_duty, duty3(100, 100, 50));
    chk("wrapacc_ready", duty_ready, 0);
    ticks(99);
    chk("wrapacc_still_old", dpwm_duty, duty3(100, 100, 50));
    tick();
    chk("wrapacc_applied", dpwm_duty, duty3(10, 20, 30));

    // clamped minimum period and mid-period change
    start(3);
    chk("pmin_ramp", ramp_ref, ramps(0, 8, 2));
    ticks(3);
    period_cfg = W'(40);
    ticks(4);                                 // cnt 7, old P still in effect
    chk("pchg_sync_old", sync, 1);
    chk("pchg_ramp_old", ramp_ref, ramps(7, 8, 2));
    tick();
    chk("pchg_ramp_new", ramp_ref, ramps(0, 40, 10));
    ticks(39);
    chk("pchg_sync_new", sync, 1);
    chk("pchg_ramp_end", ramp_ref, ramps(39, 40, 10));

    // stop finishes the period, then idles with duties forced low
    start(100);
    ticks(5);
    duty_valid = 1'b1; duty_data = duty3(40, 40, 40);
    tick();
    duty_valid = 1'b0;
    ticks(94);                                // cnt 0 of period 2
    chk("stop_duty_loaded", dpwm_duty, duty3(40, 40, 40));
    ticks(10);
    en = 1'b0;
    tick();                                   // cnt 11, STOP
    chk("stop_running", running, 1);
    chk("stop_duty_kept", dpwm_duty, duty3(40, 40, 40));
    ticks(88);
    chk("stop_sync", sync, 1);
    chk("stop_ramp_end", ramp_ref, ramps(99, 100, 25));
    tick();
    chk("stop_idle_running", running, 0);
    chk("stop_idle_ramp", ramp_ref, 0);
    chk("stop_idle_duty", dpwm_duty, 0);
    chk("stop_idle_ready", duty_ready, 0);
    chk("stop_idle_sync", sync, 0);
    ticks(3);
    chk("stop_idle_stays", running, 0);

    // re-enable during stop resumes without restart
    en = 1'b1;
    tick();
    ticks(10);
    en = 1'b0;
    tick();
    ticks(39);                                // cnt 50 in STOP
    en = 1'b1;
    tick();
    chk("resume_ramp", ramp_ref, ramps(51, 100, 25));
    chk("resume_running", running, 1);
    ticks(48);
    chk("resume_sync", sync, 1);
    ticks(6);
    chk("resume_still_run", running, 1);
    chk("resume_ramp_next", ramp_ref, ramps(5, 100, 25));

    // asynchronous reset with a full shadow
    start(100);
    ticks(5);
    duty_valid = 1'b1; duty_data = duty3(1, 2, 3);
    tick();
    duty_valid = 1'b0;
    ticks(54);                                // cnt 60
    rst = 1'b0;
    #2;
    chk("arst_ramp", ramp_ref, 0);
    chk("arst_duty", dpwm_duty, 0);
    chk("arst_running", running, 0);
    chk("arst_ready", duty_ready, 0);
    chk("arst_sync", sync, 0);
    en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("arst_idle", running, 0);
    en = 1'b1;
    tick();
    chk("arst_shadow_empty", duty_ready, 1);
    ticks(100);
    chk("arst_shadow_lost", dpwm_duty, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
